rns_mod13_mul_arbiter: RTL and testbench
========================================

Name: rns_mod13_mul_arbiter

Overview:
Shares one mul_8x8_mod_13 instance, instantiated inside this block, between two independent requesters. Arbitration is round-robin with valid/ready handshakes. The result goes to a single registered output slot with backpressure, tagged with the requester ID. Per-requester saturating accept counters support RNS channel load monitoring.

Parameters:
CNT_W, 8, width of each per-requester accept counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operand pair
req0_a  input  8  requester 0 operand A (unsigned)
req0_b  input  8  requester 0 operand B (unsigned)
req0_ready  output  1  requester 0 operand pair accepted this cycle when valid&ready
req1_valid  input  1  requester 1 has an operand pair
req1_a  input  8  requester 1 operand A
req1_b  input  8  requester 1 operand B
req1_ready  output  1  requester 1 accept strobe qualifier
res_valid  output  1  result slot holds a result
res_ready  input  1  consumer takes result when res_valid&res_ready
res_s  output  4  (A*B) mod 13, range 0..12
res_id  output  1  requester that issued the result
acc0_cnt  output  CNT_W  saturating count of requester 0 accepts
acc1_cnt  output  CNT_W  saturating count of requester 1 accepts

Behaviour:
- Reset (rst=1 at clock edge): res_valid=0, res_s=0, res_id=0, acc0_cnt=0, acc1_cnt=0, last_id=1 (so requester 0 wins first contention). Reset overrides every event in the same cycle and discards any held result.
- slot_free = !res_valid | res_ready (combinational). Full throughput: one result per cycle while res_ready=1.
- Grant, combinational:
  - only req0_valid: grant 0
  - only req1_valid: grant 1
  - both valid: grant = !last_id
  - neither valid: no grant
- reqX_ready = slot_free & (grant==X). reqX_ready may depend on the other requester's valid. It must never be asserted for both requesters in one cycle.
- Accept (reqX_valid & reqX_ready) at edge N:
  - res_s <= mul_8x8_mod_13(reqX_a, reqX_b)
  - res_id <= X
  - res_valid <= 1
  - last_id <= X
  - accX_cnt <= accX_cnt+1, saturating at 2^CNT_W-1 (holds at max, never wraps)
- Latency: operands accepted at edge N appear on res_s/res_id with res_valid=1 after edge N, i.e. during cycle N+1.
- Consume without accept at the same edge (res_valid&res_ready, no accept): res_valid <= 0. res_s/res_id keep their last values.
- Simultaneous consume and accept at one edge: the new result replaces the old one and res_valid stays 1. No bubble, no loss.
- Hold (res_valid=1, res_ready=0): res_s, res_id and res_valid are stable. Both reqX_ready=0. last_id and the counters are unchanged.
- No accept: last_id is unchanged, so fairness state persists across idle cycles.
- Requesters keep valid and operands stable until accepted. The block does not latch unaccepted operands.
- Multiplier path is purely combinational from the selected operands. A and B are muxed by the grant, and the mux defaults to requester 0's operands when there is no grant.
- Arithmetic: full 16-bit product reduced mod 13. The 4-bit result is always <= 12.
- Reset mid-operation: a pending result is dropped with res_valid=0 next cycle. After reset deasserts, the first contention goes to requester 0.

Test Plan:
- Reset values: hold rst=1 two cycles with both requesters valid -> res_valid=0, res_s=0, res_id=0, counters 0, both ready=0 during reset; after release, first contention grants req0.
- Single requester, res_ready=1: req0 A=255,B=255 -> next cycle res_valid=1, res_s=12, res_id=0, acc0_cnt=1. Then A=12,B=11 back-to-back -> res_s=2 the following cycle, no bubble.
- Contention, res_ready=1: both valid for 4 cycles with req0 (7,2) and req1 (200,3) -> grants alternate 0,1,0,1. Results are res_s=1/id0, 2/id1, 1/id0, 2/id1; acc0_cnt=2, acc1_cnt=2.
- Backpressure: req1 (100,100) accepted, res_ready=0 for 3 cycles -> res_s=3, res_id=1 held stable and both ready=0. Raise res_ready with req0 (0,77) valid -> replacement at the same edge, next res_s=0, res_id=0, res_valid stays 1.
- Counter saturation with CNT_W=2: 5 accepts from req0 -> acc0_cnt sequence 1,2,3,3,3 while acc1_cnt=0.
- Reset mid-operation: result pending with res_ready=0, assert rst one cycle -> res_valid=0 next cycle, counters 0. Afterwards both valid -> req0 granted first.

Source files
------------

// File: rtl/rns_mod13_mul_arbiter.sv
// Two-requester round-robin front end sharing one 8x8 mod-13 multiplier.
// Results land in a single registered slot tagged with the requester ID.

module mul_8x8_mod_13 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [3:0] s
);
    logic [15:0] prod;

    always_comb begin
        prod = 16'(a) * 16'(b);
        s    = 4'(prod % 16'd13);
    end
endmodule

module rns_mod13_mul_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_s,
    output logic             res_id,
    output logic [CNT_W-1:0] acc0_cnt,
    output logic [CNT_W-1:0] acc1_cnt
);
    logic       slot_free;
    logic       grant_any;
    logic       grant_id;
    logic       last_id;
    logic       accept;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [3:0] mul_s;

    // grant_id is 0 when nobody asks, so the multiplier sees requester 0 by default
    always_comb begin
        slot_free  = !res_valid || res_ready;
        grant_any  = req0_valid || req1_valid;
        grant_id   = (req0_valid && req1_valid) ? !last_id : (!req0_valid && req1_valid);
        sel_a      = grant_id ? req1_a : req0_a;
        sel_b      = grant_id ? req1_b : req0_b;
        req0_ready = !rst && slot_free && grant_any && !grant_id;
        req1_ready = !rst && slot_free && grant_id;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    mul_8x8_mod_13 u_mul (
        .a (sel_a),
        .b (sel_b),
        .s (mul_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_s     <= 4'd0;
            res_id    <= 1'b0;
            last_id   <= 1'b1;
            acc0_cnt  <= '0;
            acc1_cnt  <= '0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_s     <= mul_s;
            res_id    <= grant_id;
            last_id   <= grant_id;
            if (!grant_id && acc0_cnt != '1)
                acc0_cnt <= acc0_cnt + CNT_W'(1);
            if (grant_id && acc1_cnt != '1)
                acc1_cnt <= acc1_cnt + CNT_W'(1);
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rns_mod13_mul_arbiter.sv
// Directed bench: stimulus pushes hand-computed results into a queue, a
// negedge monitor pops and compares on every consumed result.

module tb_rns_mod13_mul_arbiter;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]       req0_a, req0_b, req1_a, req1_b;
    logic             res_valid, res_ready, res_id;
    logic [3:0]       res_s;
    logic [CNT_W-1:0] acc0_cnt, acc1_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    rns_mod13_mul_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_s      (res_s),
        .res_id     (res_id),
        .acc0_cnt   (acc0_cnt),
        .acc1_cnt   (acc1_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    task automatic push(input logic [3:0] s, input logic id);
        exp_q.push_back({s, id});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: every consumed result must match the oldest expected entry
    always @(negedge clk) begin
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                chk("res_s", int'(res_s), int'(e[4:1]));
                chk("res_id", int'(res_id), int'(e[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] sat_a [5] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    logic [3:0] sat_s [5] = '{4'd10, 4'd2, 4'd7, 4'd12, 4'd4};
    int         sat_c [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1;
        res_ready = 1'b1;
        drive(1, 8'd7, 8'd2, 1, 8'd200, 8'd3);
        step();
        @(negedge clk);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_s", int'(res_s), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_acc0", int'(acc0_cnt), 0);
        chk("rst_acc1", int'(acc1_cnt), 0);
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        step();
        rst = 1'b0;

        // contention: 7*2=14->1, 200*3=600->2, alternating from requester 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_ready0", int'(req0_ready), (i % 2 == 0) ? 1 : 0);
            chk("cont_ready1", int'(req1_ready), (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) push(4'd1, 1'b0);
            else            push(4'd2, 1'b1);
            step();
        end
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0);
        @(negedge clk);
        chk("cont_acc0", int'(acc0_cnt), 2);
        chk("cont_acc1", int'(acc1_cnt), 2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // single requester: 255*255=65025->12, then 12*11=132->2 back-to-back
        drive(1, 8'd255, 8'd255, 0, 8'd0, 8'd0);
        @(negedge clk);
        chk("single_ready0", int'(req0_ready), 1);
        push(4'd12, 1'b0);
        step();
        drive(1, 8'd12, 8'd11, 0, 8'd0, 8'd0);
        @(negedge clk);
        chk("single_acc0_1", int'(acc0_cnt), 1);
        chk("single_ready0_b2b", int'(req0_ready), 1);
        push(4'd2, 1'b0);
        step();
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0);
        @(negedge clk);
        chk("single_no_bubble", int'(res_valid), 1);
        chk("single_acc0_2", int'(acc0_cnt), 2);
        step();

        // backpressure: 100*100=10000->3 held, then replaced by 0*77=0
        res_ready = 1'b0;
        drive(0, 8'd0, 8'd0, 1, 8'd100, 8'd100);
        @(negedge clk);
        chk("bp_ready1", int'(req1_ready), 1);
        push(4'd3, 1'b1);
        step();
        drive(1, 8'd0, 8'd77, 0, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(res_valid), 1);
            chk("bp_hold_s", int'(res_s), 3);
            chk("bp_hold_id", int'(res_id), 1);
            chk("bp_hold_ready0", int'(req0_ready), 0);
            chk("bp_hold_ready1", int'(req1_ready), 0);
            chk("bp_hold_acc1", int'(acc1_cnt), 1);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_replace_ready0", int'(req0_ready), 1);
        push(4'd0, 1'b0);
        step();
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0);
        @(negedge clk);
        chk("bp_replace_valid", int'(res_valid), 1);
        chk("bp_acc0", int'(acc0_cnt), 3);
        step();

        // saturation of a 2-bit counter
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, sat_a[i], 8'd5, 0, 8'd0, 8'd0);
            @(negedge clk);
            chk("sat_ready0", int'(req0_ready), 1);
            push(sat_s[i], 1'b0);
            step();
            chk("sat_acc0", int'(acc0_cnt), sat_c[i]);
            chk("sat_acc1", int'(acc1_cnt), 0);
        end
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0);
        step();

        // reset while a result is pending
        res_ready = 1'b0;
        drive(1, 8'd12, 8'd11, 0, 8'd0, 8'd0);
        step();
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0);
        chk("mid_pending", int'(res_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_dropped", int'(res_valid), 0);
        chk("mid_acc0", int'(acc0_cnt), 0);
        chk("mid_acc1", int'(acc1_cnt), 0);
        res_ready = 1'b1;
        drive(1, 8'd7, 8'd2, 1, 8'd200, 8'd3);
        @(negedge clk);
        chk("mid_first_ready0", int'(req0_ready), 1);
        chk("mid_first_ready1", int'(req1_ready), 0);
        push(4'd1, 1'b0);
        step();
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0);
        repeat (3) step();

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
